mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for mem_ack.
REQ-002 SHALL have port CLK, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port ex_valid, input, 1: execute-stage bundle valid.
REQ-005 SHALL have port ex_rd, input, 5: destination register.
REQ-006 SHALL have port ex_result, input, 64: ALU result, or effective address when loading.
REQ-007 SHALL have port ex_write_back, input, 1: instruction writes rd.
REQ-008 SHALL have port ex_load_flag, input, 1: instruction is a load.
REQ-009 SHALL have port ex_funct3, input, 3: load width/sign code.
REQ-010 SHALL have port mem_req, output, 1: read request, held until ack or timeout.
REQ-011 SHALL have port mem_addr, output, 64: doubleword-aligned read address.
REQ-012 SHALL have port mem_rdata, input, 64: read data, valid when mem_ack=1.
REQ-013 SHALL have port mem_ack, input, 1: single-cycle read completion.
REQ-014 SHALL have port wb_rd, output, 5: write-back register index.
REQ-015 SHALL have port wb_value, output, 64: write-back data.
REQ-016 SHALL have port wb_en, output, 1: one-cycle write-back strobe, never set for rd=0.
REQ-017 SHALL have port stall, output, 1: upstream must hold its ex_* bundle while stall is high.
REQ-018 SHALL have port load_err, output, 1: one-cycle pulse on misaligned, illegal or timed-out load.

Function
REQ-019 SHALL sample the ex_* bundle only in cycles where ex_valid=1 and stall=0.
REQ-020 SHALL, for an accepted non-load, drive wb_rd=ex_rd, wb_value=ex_result and wb_en=ex_write_back&&(ex_rd!=0) on the next cycle; latency 1; stall stays 0.
REQ-021 SHALL use states IDLE and WAIT; stall=1 exactly while in WAIT.
REQ-022 SHALL, for an accepted legal aligned load, latch rd, funct3 and addr[2:0], then next cycle enter WAIT with mem_req=1 and mem_addr={addr[63:3],3'b000}.
REQ-023 SHALL hold mem_req and mem_addr stable in WAIT until mem_ack.
REQ-024 SHALL, on mem_ack in WAIT, on the next cycle drop mem_req, return to IDLE, and drive wb_en=(rd!=0) with the extracted wb_value.
REQ-025 SHALL extract data as follows: LB/LH/LW/LD (funct3 0/1/2/3) sign-extend, and LBU/LHU/LWU (4/5/6) zero-extend, the byte lane selected by addr[2:0].
REQ-026 SHALL treat as misaligned: LH/LHU with addr[0]!=0, LW/LWU with addr[1:0]!=0, LD with addr[2:0]!=0; funct3=7 is illegal.
REQ-027 SHALL, for a misaligned or illegal load, issue no mem_req, assert wb_en=0 and load_err=1 for one cycle, and stay IDLE.
REQ-028 SHALL count WAIT cycles with a width of clog2(TIMEOUT)+1 bits; if the count reaches TIMEOUT without ack, it SHALL drop mem_req, pulse load_err, suppress wb_en and return to IDLE.
REQ-029 SHALL, when mem_ack arrives in the same cycle the count reaches TIMEOUT, take the ack (normal write-back, no load_err).
REQ-030 SHALL ignore mem_ack while in IDLE.
REQ-031 SHALL drive wb_en=0 and load_err=0 in every cycle with no completing instruction; wb_rd and wb_value hold their last values.
REQ-032 SHALL allow a new instruction to be accepted in the same cycle that wb_en is high for the previous one.

Reset
REQ-033 SHALL, on reset, enter IDLE and clear mem_req, mem_addr, wb_rd, wb_value, wb_en, stall, load_err and the timeout counter, taking effect at the next rising edge.
REQ-034 SHALL, when reset occurs in WAIT, deassert mem_req at that edge, discard the pending load, and produce no write-back.

Structure
REQ-035 SHALL place the load funct3 encodings, the state encoding and the TIMEOUT default in the shared core package.
REQ-036 SHALL implement lane select and sign/zero extension in a combinational sub-module named load_extract.

Verification
REQ-037 SHALL cover this scenario: non-load, rd=5, result=0x1234, write_back=1 -> next cycle wb_en=1, wb_rd=5, wb_value=0x1234, stall=0.
REQ-038 SHALL cover this scenario: LB at addr 0x1003, with ack after 3 cycles and rdata=0x00000000_80000000 -> mem_addr=0x1000, stall=1 for 4 cycles, wb_value=0xFFFFFFFF_FFFFFF80.
REQ-039 SHALL cover this scenario: LWU at addr 0x2004, rdata=0xDEADBEEF_00000000 -> wb_value=0x00000000_DEADBEEF.
REQ-040 SHALL cover this scenario: LW at addr 0x3002 -> no mem_req, load_err pulse, wb_en=0; also funct3=7 -> load_err.
REQ-041 SHALL cover this scenario: LD with no ack, TIMEOUT=64 -> mem_req for exactly 64 cycles, then load_err pulse and stall=0; also ack on cycle 64 -> normal write-back.
REQ-042 SHALL cover this scenario: reset asserted mid-WAIT -> mem_req=0 after the edge, no wb_en, and a subsequent non-load completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared core definitions for the load/store memory-access stage:
// load funct3 encodings, FSM state encoding, timeout default and alignment rule.
package mem_access_pkg;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        F3_LB      = 3'd0,
        F3_LH      = 3'd1,
        F3_LW      = 3'd2,
        F3_LD      = 3'd3,
        F3_LBU     = 3'd4,
        F3_LHU     = 3'd5,
        F3_LWU     = 3'd6,
        F3_ILLEGAL = 3'd7
    } load_funct3_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // A load is rejected when its byte offset is not a multiple of its width,
    // or when the width code is the unused encoding.
    function automatic logic load_is_bad(input logic [2:0] funct3, input logic [2:0] offset);
        logic bad;
        case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = offset[0];
            F3_LW, F3_LWU: bad = |offset[1:0];
            F3_LD:         bad = |offset;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Selects the addressed lane of a doubleword read and sign- or zero-extends it
// according to the load width code.
module load_extract
    import mem_access_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_offset,
    output logic [63:0] o_value
);

    logic [63:0] w_lane;

    // Shifting the addressed byte to bit 0 lets every width read from the bottom.
    assign w_lane = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_value = '0;
        case (i_funct3)
            F3_LB:   o_value = {{56{w_lane[7]}},  w_lane[7:0]};
            F3_LH:   o_value = {{48{w_lane[15]}}, w_lane[15:0]};
            F3_LW:   o_value = {{32{w_lane[31]}}, w_lane[31:0]};
            F3_LD:   o_value = w_lane;
            F3_LBU:  o_value = {56'd0, w_lane[7:0]};
            F3_LHU:  o_value = {48'd0, w_lane[15:0]};
            F3_LWU:  o_value = {32'd0, w_lane[31:0]};
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results to write-back in one cycle and
// performs blocking doubleword reads for loads, with alignment and timeout checks.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [63:0] ex_result,
    input  logic        ex_write_back,
    input  logic        ex_load_flag,
    input  logic [2:0]  ex_funct3,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_value,
    output logic        wb_en,
    output logic        stall,
    output logic        load_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_e             r_state,      w_state_next;
    logic               r_mem_req,    w_mem_req_next;
    logic [63:0]        r_mem_addr,   w_mem_addr_next;
    logic [4:0]         r_wb_rd,      w_wb_rd_next;
    logic [63:0]        r_wb_value,   w_wb_value_next;
    logic               r_wb_en,      w_wb_en_next;
    logic               r_load_err,   w_load_err_next;
    logic [CNT_W-1:0]   r_count,      w_count_next;
    logic [4:0]         r_ld_rd,      w_ld_rd_next;
    logic [2:0]         r_ld_funct3,  w_ld_funct3_next;
    logic [2:0]         r_ld_offset,  w_ld_offset_next;

    logic               w_accept;
    logic [CNT_W-1:0]   w_count_inc;
    logic [63:0]        w_extracted;

    assign w_accept    = ex_valid && (r_state == ST_IDLE);
    assign w_count_inc = r_count + CNT_W'(1);

    load_extract u_load_extract (
        .i_rdata  (mem_rdata),
        .i_funct3 (r_ld_funct3),
        .i_offset (r_ld_offset),
        .o_value  (w_extracted)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        w_state_next     = r_state;
        w_mem_req_next   = r_mem_req;
        w_mem_addr_next  = r_mem_addr;
        w_wb_rd_next     = r_wb_rd;
        w_wb_value_next  = r_wb_value;
        w_wb_en_next     = 1'b0;
        w_load_err_next  = 1'b0;
        w_count_next     = r_count;
        w_ld_rd_next     = r_ld_rd;
        w_ld_funct3_next = r_ld_funct3;
        w_ld_offset_next = r_ld_offset;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!ex_load_flag) begin
                        w_wb_rd_next    = ex_rd;
                        w_wb_value_next = ex_result;
                        w_wb_en_next    = ex_write_back && (ex_rd != 5'd0);
                    end else if (load_is_bad(ex_funct3, ex_result[2:0])) begin
                        w_load_err_next = 1'b1;
                    end else begin
                        w_state_next     = ST_WAIT;
                        w_mem_req_next   = 1'b1;
                        w_mem_addr_next  = {ex_result[63:3], 3'b000};
                        w_ld_rd_next     = ex_rd;
                        w_ld_funct3_next = ex_funct3;
                        w_ld_offset_next = ex_result[2:0];
                        w_count_next     = '0;
                    end
                end
            end

            ST_WAIT: begin
                // An ack in the final permitted cycle still wins over the timeout.
                if (mem_ack) begin
                    w_state_next    = ST_IDLE;
                    w_mem_req_next  = 1'b0;
                    w_wb_rd_next    = r_ld_rd;
                    w_wb_value_next = w_extracted;
                    w_wb_en_next    = (r_ld_rd != 5'd0);
                    w_count_next    = '0;
                end else if (w_count_inc == CNT_W'(TIMEOUT)) begin
                    w_state_next    = ST_IDLE;
                    w_mem_req_next  = 1'b0;
                    w_load_err_next = 1'b1;
                    w_count_next    = '0;
                end else begin
                    w_count_next    = w_count_inc;
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_wb_rd     <= '0;
            r_wb_value  <= '0;
            r_wb_en     <= 1'b0;
            r_load_err  <= 1'b0;
            r_count     <= '0;
            r_ld_rd     <= '0;
            r_ld_funct3 <= '0;
            r_ld_offset <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state     <= w_state_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_addr  <= w_mem_addr_next;
            r_wb_rd     <= w_wb_rd_next;
            r_wb_value  <= w_wb_value_next;
            r_wb_en     <= w_wb_en_next;
            r_load_err  <= w_load_err_next;
            r_count     <= w_count_next;
            r_ld_rd     <= w_ld_rd_next;
            r_ld_funct3 <= w_ld_funct3_next;
            r_ld_offset <= w_ld_offset_next;
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign wb_rd    = r_wb_rd;
    assign wb_value = r_wb_value;
    assign wb_en    = r_wb_en;
    assign load_err = r_load_err;
    assign stall    = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: completions are queued at issue time and
// compared when wb_en or load_err appears.
module tb_mem_access;

    localparam int TO = 64;

    logic        CLK = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result;
    logic        ex_write_back;
    logic        ex_load_flag;
    logic [2:0]  ex_funct3;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value;
    logic        wb_en;
    logic        stall;
    logic        load_err;

    typedef struct {
        logic        is_err;
        logic [4:0]  rd;
        logic [63:0] value;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_write_back (ex_write_back),
        .ex_load_flag  (ex_load_flag),
        .ex_funct3     (ex_funct3),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .wb_rd         (wb_rd),
        .wb_value      (wb_value),
        .wb_en         (wb_en),
        .stall         (stall),
        .load_err      (load_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    // Reference extraction written byte by byte, independent of the RTL shifter.
    function automatic logic [63:0] model(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] d);
        int          nbytes;
        logic [63:0] v;
        logic        sgn;
        nbytes = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < 8; i++)
            if (i < nbytes) v[i*8 +: 8] = d[(int'(off) + i)*8 +: 8];
        sgn = v[nbytes*8-1];
        if (!f3[2] && sgn)
            for (int i = 0; i < 8; i++)
                if (i >= nbytes) v[i*8 +: 8] = 8'hFF;
        return v;
    endfunction

    always @(negedge CLK) begin
        if (!reset && (wb_en || load_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {62'd0, wb_en, load_err}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_kind", {62'd0, wb_en, load_err}, mon_e.is_err ? 64'd1 : 64'd2);
                if (!mon_e.is_err) begin
                    check("wb_rd", {59'd0, wb_rd}, {59'd0, mon_e.rd});
                    check("wb_value", wb_value, mon_e.value);
                end
            end
        end
    end

    task automatic push_wb(input logic [4:0] rd, input logic [63:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.rd     = rd;
        e.value  = v;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.rd     = '0;
        e.value  = '0;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [63:0] res, input logic wb,
                         input logic ld, input logic [2:0] f3);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_result     = res;
        ex_write_back = wb;
        ex_load_flag  = ld;
        ex_funct3     = f3;
        @(posedge CLK);
        #1;
        ex_valid      = 1'b0;
        ex_rd         = 5'($urandom);
        ex_result     = {$urandom, $urandom};
        ex_write_back = 1'($urandom);
        ex_load_flag  = 1'($urandom);
        ex_funct3     = 3'($urandom);
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [63:0] res, input logic wb);
        if (wb && rd != 5'd0) push_wb(rd, res);
        issue(rd, res, wb, 1'b0, 3'd0);
        check("alu_stall", {63'd0, stall}, 64'd0);
    endtask

    task automatic do_bad_load(input logic [4:0] rd, input logic [63:0] addr, input logic [2:0] f3);
        push_err();
        issue(rd, addr, 1'b1, 1'b1, f3);
        check("bad_req", {63'd0, mem_req}, 64'd0);
        check("bad_stall", {63'd0, stall}, 64'd0);
    endtask

    // ack_at: WAIT cycle (1-based) in which mem_ack is driven; 0 means never.
    task automatic do_load(input logic [4:0] rd, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] rdata, input int ack_at, input logic [63:0] exp_val);
        int          n_req;
        int          n_stall;
        int          exp_cycles;
        logic        addr_bad;
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        if (ack_at >= 1 && ack_at <= TO) begin
            exp_cycles = ack_at;
            if (rd != 5'd0) push_wb(rd, exp_val);
        end else begin
            exp_cycles = TO;
            push_err();
        end
        issue(rd, addr, 1'b1, 1'b1, f3);
        check("ld_req", {63'd0, mem_req}, 64'd1);
        check("ld_addr", mem_addr, exp_addr);
        n_req    = 0;
        n_stall  = 0;
        addr_bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!mem_req) break;
            n_req++;
            if (stall) n_stall++;
            if (mem_addr !== exp_addr) addr_bad = 1'b1;
            if (n_req == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(posedge CLK);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
        check("ld_req_cycles", 64'(n_req), 64'(exp_cycles));
        check("ld_stall_cycles", 64'(n_stall), 64'(exp_cycles));
        check("ld_addr_stable", {63'd0, addr_bad}, 64'd0);
        check("ld_stall_end", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_rd         = '0;
        ex_result     = '0;
        ex_write_back = 1'b0;
        ex_load_flag  = 1'b0;
        ex_funct3     = '0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_mem_req",  {63'd0, mem_req}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_wb_en",    {63'd0, wb_en}, 64'd0);
        check("rst_wb_rd",    {59'd0, wb_rd}, 64'd0);
        check("rst_wb_value", wb_value, 64'd0);
        check("rst_stall",    {63'd0, stall}, 64'd0);
        check("rst_load_err", {63'd0, load_err}, 64'd0);
        reset = 1'b0;

        // Plain ALU results, rd=0 suppression, write_back=0, back-to-back issue.
        do_alu(5'd5, 64'h1234, 1'b1);
        do_alu(5'd0, 64'hAAAA, 1'b1);
        do_alu(5'd9, 64'h5555, 1'b0);
        do_alu(5'd1, 64'h1111_2222_3333_4444, 1'b1);
        do_alu(5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        do_alu(5'd31, 64'h8000_0000_0000_0001, 1'b1);

        // Sign-extended byte, then an ALU op accepted while the load writes back.
        do_load(5'd7, 64'h1003, 3'd0, 64'h0000_0000_8000_0000, 4, 64'hFFFF_FFFF_FFFF_FF80);
        do_alu(5'd8, 64'hCAFE, 1'b1);
        do_load(5'd10, 64'h2004, 3'd6, 64'hDEAD_BEEF_0000_0000, 1, 64'h0000_0000_DEAD_BEEF);
        do_load(5'd11, 64'h2006, 3'd1, 64'h8001_0000_0000_0000, 2, 64'hFFFF_FFFF_FFFF_8001);

        // Misaligned and illegal encodings.
        do_bad_load(5'd3, 64'h3002, 3'd2);
        do_bad_load(5'd3, 64'h4000, 3'd7);
        do_bad_load(5'd4, 64'h5001, 3'd1);
        do_bad_load(5'd4, 64'h6004, 3'd3);
        do_bad_load(5'd4, 64'h7003, 3'd5);

        // Timeout without ack, and ack arriving in the last permitted cycle.
        do_load(5'd12, 64'h8000, 3'd3, 64'h0, 0, 64'h0);
        do_load(5'd13, 64'h8008, 3'd3, 64'h0123_4567_89AB_CDEF, TO, 64'h0123_4567_89AB_CDEF);

        // Random aligned loads checked against the byte-wise model.
        for (int k = 0; k < 8; k++) begin
            logic [2:0]  f3;
            logic [2:0]  off;
            logic [63:0] addr;
            logic [63:0] rdata;
            logic [4:0]  rd;
            f3    = 3'($urandom_range(0, 6));
            off   = 3'($urandom_range(0, 7)) & ~3'((1 << f3[1:0]) - 1);
            addr  = {$urandom, $urandom};
            addr  = {addr[63:3], off};
            rdata = {$urandom, $urandom};
            rd    = 5'($urandom);
            do_load(rd, addr, f3, rdata, int'($urandom_range(1, 5)), model(f3, off, rdata));
        end

        // Reset in the middle of WAIT discards the load.
        issue(5'd20, 64'h9000, 1'b1, 1'b1, 3'd3);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_stall",   {63'd0, stall}, 64'd0);
        check("midrst_wb_en",   {63'd0, wb_en}, 64'd0);
        reset = 1'b0;

        // Ack in IDLE must be ignored, then normal operation resumes.
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        check("idle_ack_stall", {63'd0, stall}, 64'd0);
        do_alu(5'd6, 64'hBEEF, 1'b1);

        repeat (3) @(posedge CLK);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
